// File: rtl/psram_pkg.sv
// Shared types and default widths for the cram0 PSRAM arbiter.
package psram_pkg;

    localparam int unsigned PSRAM_ADDR_WIDTH = 22;
    localparam int unsigned PSRAM_DATA_WIDTH = 16;
    localparam int unsigned PSRAM_MASK_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } psram_state_e;

    typedef struct packed {
        logic                        we;
        logic [PSRAM_ADDR_WIDTH-1:0] addr;
        logic [PSRAM_DATA_WIDTH-1:0] wdata;
        logic [PSRAM_MASK_WIDTH-1:0] mask;
    } psram_cmd_t;

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester and controller handshake bundle; master = arbiter side, slave = requesters plus controller.
interface psram_arbiter_if
    import psram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PSRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PSRAM_DATA_WIDTH
) ();

    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [1:0]            req0_mask;
    logic                  req0_ready;
    logic                  req0_done;
    logic [DATA_WIDTH-1:0] req0_rdata;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [1:0]            req1_mask;
    logic                  req1_ready;
    logic                  req1_done;
    logic [DATA_WIDTH-1:0] req1_rdata;

    logic                  mem_valid;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_mask;
    logic                  mem_ready;
    logic                  mem_done;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_mask,
        output req0_ready, req0_done, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_mask,
        output req1_ready, req1_done, req1_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_ready, mem_done, mem_rdata
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_mask,
        input  req0_ready, req0_done, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_mask,
        input  req1_ready, req1_done, req1_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_ready, mem_done, mem_rdata
    );

endinterface

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller port between scanout (0) and loader (1).
// One transaction in flight; a watchdog forces release if the controller never completes.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PSRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PSRAM_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    psram_arbiter_if.master bus,
    output logic            timeout_err
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    psram_state_e                 state_q, state_d;
    psram_cmd_t                   cmd_q, cmd_d;
    logic                         grant_q, grant_d;
    logic                         last_q, last_d;
    logic [WDOG_W-1:0]            wdog_q, wdog_d;
    logic                         mem_valid_q, mem_valid_d;
    logic [1:0]                   ready_q, ready_d;
    logic [1:0]                   done_q, done_d;
    logic [1:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                         terr_q, terr_d;
    logic                         pick;

    // On a tie the requester that did not finish last wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : v1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            wdog_q      <= '0;
            mem_valid_q <= 1'b0;
            ready_q     <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wdog_q      <= wdog_d;
            mem_valid_q <= mem_valid_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            terr_q      <= terr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wdog_d      = wdog_q;
        mem_valid_d = mem_valid_q;
        ready_d     = '0;
        done_d      = '0;
        rdata_d     = rdata_q;
        terr_d      = terr_q;
        pick        = rr_pick(bus.req0_valid, bus.req1_valid, last_q);

        unique case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_d = pick;
                    if (pick) begin
                        cmd_d = '{we:    bus.req1_we,
                                  addr:  PSRAM_ADDR_WIDTH'(bus.req1_addr),
                                  wdata: PSRAM_DATA_WIDTH'(bus.req1_wdata),
                                  mask:  bus.req1_mask};
                    end else begin
                        cmd_d = '{we:    bus.req0_we,
                                  addr:  PSRAM_ADDR_WIDTH'(bus.req0_addr),
                                  wdata: PSRAM_DATA_WIDTH'(bus.req0_wdata),
                                  mask:  bus.req0_mask};
                    end
                    ready_d[pick] = 1'b1;
                    mem_valid_d   = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    wdog_d      = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (bus.mem_done) begin
                    done_d[grant_q] = 1'b1;
                    if (!cmd_q.we) begin
                        rdata_d[grant_q] = DATA_WIDTH'(bus.mem_rdata);
                    end
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                        done_d[grant_q] = 1'b1;
                        terr_d          = 1'b1;
                        last_d          = grant_q;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_rdata = rdata_q[0];
    assign bus.req1_rdata = rdata_q[1];
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_we     = cmd_q.we;
    assign bus.mem_addr   = ADDR_WIDTH'(cmd_q.addr);
    assign bus.mem_wdata  = DATA_WIDTH'(cmd_q.wdata);
    assign bus.mem_mask   = cmd_q.mask;
    assign timeout_err    = terr_q;

endmodule
